// File: rtl/direction_controller.sv
// Snake direction controller: button edges -> heading with reversal rejection, one step strobe per game tick.
// Optional DIR_QUEUE_EN deepens the pending-turn store from a 1-entry register to a 2-entry FIFO.
module direction_controller #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       edge_collision,
  output logic       l,
  output logic       r,
  output logic       u,
  output logic       d,
  output logic [1:0] heading,
  output logic       running
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  state_t           state_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [1:0]       heading_q;
  logic [3:0]       strobe_q;
  logic             running_q;
  logic [3:0]       btn_q;

  logic [3:0] btn_now;
  logic [3:0] press;
  logic       press_vld;
  logic [1:0] press_dir;
  logic       tc;
  logic       live;
  logic       pop;
  logic       pend_vld;
  logic [1:0] pend_dir;
  logic [1:0] heading_pop;
  logic [1:0] ref_dir;
  logic       room;
  logic       accept;

  // Bit index equals the heading code, so strobe bits line up with heading values.
  assign btn_now   = {btn_d, btn_u, btn_r, btn_l};
  assign press     = btn_now & ~btn_q;
  assign press_vld = |press;

  always_comb begin
    press_dir = DIR_D;
    if (press[0])      press_dir = DIR_L;
    else if (press[1]) press_dir = DIR_R;
    else if (press[2]) press_dir = DIR_U;
  end

  assign tc          = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign live        = (state_q == RUN) && !edge_collision;
  assign pop         = live && tc && pend_vld;
  assign heading_pop = pop ? pend_dir : heading_q;
  // Opposite direction differs only in bit 0 (L/R, U/D).
  assign accept      = live && press_vld && room &&
                       (press_dir != ref_dir) &&
                       (press_dir != {ref_dir[1], ~ref_dir[0]});

`ifdef DIR_QUEUE_EN
  logic [1:0][1:0] fifo_q, fifo_d;
  logic [1:0]      count_q, count_d;
  logic [1:0]      count_pop;

  assign pend_vld  = (count_q != 2'd0);
  assign pend_dir  = fifo_q[0];
  assign count_pop = count_q - {1'b0, pop};
  // The newest entry survives a pop unless the pop empties the FIFO.
  assign ref_dir   = (count_pop == 2'd0) ? heading_pop :
                     (count_q[1] ? fifo_q[1] : fifo_q[0]);
  assign room      = (count_pop != 2'd2);

  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_pop;
    if (pop) fifo_d[0] = fifo_q[1];
    if (accept) begin
      fifo_d[count_pop[0]] = press_dir;
      count_d              = count_pop + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state_q == RUN && edge_collision)) begin
      fifo_q  <= '0;
      count_q <= 2'd0;
    end else begin
      fifo_q  <= fifo_d;
      count_q <= count_d;
    end
  end
`else
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_dir_q, pend_dir_d;

  assign pend_vld = pend_vld_q;
  assign pend_dir = pend_dir_q;
  assign ref_dir  = heading_pop;
  assign room     = 1'b1;

  always_comb begin
    pend_vld_d = pend_vld_q && !pop;
    pend_dir_d = pend_dir_q;
    if (accept) begin
      pend_vld_d = 1'b1;
      pend_dir_d = press_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state_q == RUN && edge_collision)) begin
      pend_vld_q <= 1'b0;
      pend_dir_q <= DIR_L;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      heading_q  <= DIR_R;
      strobe_q   <= 4'b0000;
      running_q  <= 1'b0;
      btn_q      <= 4'b0000;
    end else begin
      btn_q    <= btn_now;
      strobe_q <= 4'b0000;
      case (state_q)
        IDLE: begin
          tick_cnt_q <= '0;
          if (press_vld) begin
            heading_q <= press_dir;
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (edge_collision) begin
            state_q    <= HALT;
            running_q  <= 1'b0;
            tick_cnt_q <= '0;
          end else if (tc) begin
            tick_cnt_q <= '0;
            heading_q  <= heading_pop;
            strobe_q   <= 4'b0001 << heading_pop;
          end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= HALT;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign {d, u, r, l} = strobe_q;
  assign heading      = heading_q;
  assign running      = running_q;

endmodule

// File: tb/tb_direction_controller.sv
// Scenario bench for direction_controller at TICK_DIV=4; expected strobes queue up ahead of the DUT.
module tb_direction_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       edge_collision = 1'b0;
  logic       l, r, u, d;
  logic [1:0] heading;
  logic       running;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [1:0] sb[$];

  localparam logic [1:0] H_L = 2'b00, H_R = 2'b01, H_U = 2'b10, H_D = 2'b11;

  direction_controller #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .edge_collision(edge_collision),
    .l(l), .r(r), .u(u), .d(d),
    .heading(heading), .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

  // Every strobe cycle consumes one expected heading from the scoreboard.
  always @(negedge clk) begin
    if (!reset && (l || r || u || d)) begin
      check_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_strobe: got dulr=%b heading=%b, required no strobe", {d, u, r, l}, heading);
      end else begin
        logic [1:0] exp;
        exp = sb.pop_front();
        if ({heading, d, u, r, l} !== {exp, onehot(exp)})
          $display("FAIL strobe: got heading=%b dulr=%b, required heading=%b dulr=%b",
                   heading, {d, u, r, l}, exp, onehot(exp));
        else
          pass_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(20);
    check_cnt++;
    if ({d, u, r, l} !== 4'b0000) $display("FAIL reset_strobes: got %b, required 0000", {d, u, r, l});
    else pass_cnt++;
    check_cnt++;
    if (running !== 1'b0) $display("FAIL reset_running: got %b, required 0", running);
    else pass_cnt++;
    check_cnt++;
    if (heading !== H_R) $display("FAIL reset_heading: got %b, required %b", heading, H_R);
    else pass_cnt++;
    $display("reset: heading=%b running=%b", heading, running);
  endtask

  task automatic test_start_up;
    sb.push_back(H_U); sb.push_back(H_U); sb.push_back(H_U);
    btn_u = 1'b1;
    step(1);
    btn_u = 1'b0;
    check_cnt++;
    if (running !== 1'b1) $display("FAIL start_running: got %b, required 1", running);
    else pass_cnt++;
    step(13);
    check_cnt++;
    if (heading !== H_U) $display("FAIL start_heading: got %b, required %b", heading, H_U);
    else pass_cnt++;
    check_cnt++;
    if (sb.size() != 0) $display("FAIL start_strobe_count: got %0d pending, required 0", sb.size());
    else pass_cnt++;
    $display("start_up: heading=%b running=%b", heading, running);
  endtask

  task automatic test_reversal;
    sb.push_back(H_U); sb.push_back(H_L);
    btn_d = 1'b1;
    step(1);
    btn_d = 1'b0;
    step(2);
    btn_l = 1'b1;
    step(1);
    btn_l = 1'b0;
    step(4);
    check_cnt++;
    if (heading !== H_L) $display("FAIL reversal_heading: got %b, required %b", heading, H_L);
    else pass_cnt++;
    check_cnt++;
    if (sb.size() != 0) $display("FAIL reversal_strobe_count: got %0d pending, required 0", sb.size());
    else pass_cnt++;
    $display("reversal: heading=%b", heading);
  endtask

  task automatic test_simultaneous;
    sb.push_back(H_U); sb.push_back(H_L); sb.push_back(H_L);
    btn_u = 1'b1;
    step(1);
    btn_u = 1'b0;
    step(2);
    btn_l = 1'b1;
    btn_d = 1'b1;
    step(1);
    btn_l = 1'b0;
    btn_d = 1'b0;
    step(8);
    check_cnt++;
    if (heading !== H_L) $display("FAIL simultaneous_heading: got %b, required %b", heading, H_L);
    else pass_cnt++;
    check_cnt++;
    if (sb.size() != 0) $display("FAIL simultaneous_strobe_count: got %0d pending, required 0", sb.size());
    else pass_cnt++;
    $display("simultaneous: heading=%b", heading);
  endtask

  task automatic test_collision;
    edge_collision = 1'b1;
    step(1);
    edge_collision = 1'b0;
    check_cnt++;
    if (running !== 1'b0) $display("FAIL halt_running: got %b, required 0", running);
    else pass_cnt++;
    step(20);
    btn_u = 1'b1;
    step(1);
    btn_u = 1'b0;
    step(20);
    check_cnt++;
    if ({running, d, u, r, l} !== 5'b00000)
      $display("FAIL halt_outputs: got running=%b dulr=%b, required 0 0000", running, {d, u, r, l});
    else pass_cnt++;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_cnt++;
    if (heading !== H_R) $display("FAIL halt_reset_heading: got %b, required %b", heading, H_R);
    else pass_cnt++;
    check_cnt++;
    if (running !== 1'b0) $display("FAIL halt_reset_running: got %b, required 0", running);
    else pass_cnt++;
    $display("collision: halted then reset, heading=%b", heading);
  endtask

  task automatic test_quick_turns;
    logic [1:0] final_dir;
    edge_collision = 1'b1;
    step(1);
    edge_collision = 1'b0;
    check_cnt++;
    if (running !== 1'b0) $display("FAIL idle_collision_running: got %b, required 0", running);
    else pass_cnt++;
    btn_r = 1'b1;
    step(1);
    btn_r = 1'b0;
    check_cnt++;
    if ({running, heading} !== {1'b1, H_R})
      $display("FAIL quick_start: got running=%b heading=%b, required 1 %b", running, heading, H_R);
    else pass_cnt++;
`ifdef DIR_QUEUE_EN
    sb.push_back(H_U); sb.push_back(H_L);
    final_dir = H_L;
`else
    sb.push_back(H_D); sb.push_back(H_D);
    final_dir = H_D;
`endif
    btn_u = 1'b1;
    step(1);
    btn_u = 1'b0;
    step(1);
`ifdef DIR_QUEUE_EN
    btn_l = 1'b1;
`else
    btn_d = 1'b1;
`endif
    step(1);
    btn_l = 1'b0;
    btn_d = 1'b0;
    step(6);
    check_cnt++;
    if (heading !== final_dir) $display("FAIL quick_heading: got %b, required %b", heading, final_dir);
    else pass_cnt++;
    check_cnt++;
    if (sb.size() != 0) $display("FAIL quick_strobe_count: got %0d pending, required 0", sb.size());
    else pass_cnt++;
    $display("quick_turns: heading=%b", heading);
  endtask

  initial begin
    test_reset();
    test_start_up();
    test_reversal();
    test_simultaneous();
    test_collision();
    test_quick_turns();
    step(2);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
